// File: rtl/vector_program_sequencer.sv
// Loads a program into the vector datapath instruction memory over a valid/ready stream, then
// runs the datapath until it halts or RUN_LIMIT expires. Optional checksum port: VPS_CHECKSUM_EN.
module vector_program_sequencer #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int RUN_LIMIT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   load_count_i,
  input  logic [2:0]            vsew_i,
  input  logic                  abort_i,
  input  logic                  inst_valid_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  output logic                  inst_ready_o,
  output logic                  inst_we_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  output logic [INST_WIDTH-1:0] instruction_o,
  output logic [2:0]            vsew_o,
  input  logic                  dp_halt_i,
  output logic                  dp_run_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic                  err_o,
`ifdef VPS_CHECKSUM_EN
  output logic [INST_WIDTH-1:0] checksum_o,
`endif
  output logic [15:0]           exec_count_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [31:0]         LIMIT_C = 32'(RUN_LIMIT);

  state_t                state_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH-1:0] index_r;
  logic [31:0]           run_cnt_r;

  logic        hs_s;
  logic        accept_s;
  logic        last_s;
  logic [31:0] run_nxt_s;
  logic        limit_s;
  logic [15:0] exec_sat_s;

  // Handshake, start qualification and run-counter decode
  always_comb begin
    hs_s       = inst_valid_i & inst_ready_o;
    accept_s   = (load_count_i != (ADDR_WIDTH+1)'(0)) && (load_count_i <= DEPTH_C);
    last_s     = (({1'b0, index_r} + (ADDR_WIDTH+1)'(1)) == count_r);
    run_nxt_s  = run_cnt_r + 32'd1;
    limit_s    = (run_nxt_s == LIMIT_C);
    if (run_nxt_s > 32'h0000_FFFF) begin
      exec_sat_s = 16'hFFFF;
    end else begin
      exec_sat_s = run_nxt_s[15:0];
    end
  end

  // Sequencer FSM with registered outputs; abort overrides every other transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      count_r       <= '0;
      index_r       <= '0;
      run_cnt_r     <= 32'd0;
      inst_ready_o  <= 1'b0;
      inst_we_o     <= 1'b0;
      inst_addr_o   <= '0;
      instruction_o <= '0;
      vsew_o        <= 3'd0;
      dp_run_o      <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      timeout_o     <= 1'b0;
      err_o         <= 1'b0;
      exec_count_o  <= 16'd0;
`ifdef VPS_CHECKSUM_EN
      checksum_o    <= '0;
`endif
    end else begin
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      inst_we_o <= 1'b0;
      if (abort_i) begin
        state_r      <= IDLE;
        inst_ready_o <= 1'b0;
        dp_run_o     <= 1'b0;
        busy_o       <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start_i && accept_s) begin
              state_r      <= LOAD;
              count_r      <= load_count_i;
              vsew_o       <= vsew_i;
              index_r      <= '0;
              timeout_o    <= 1'b0;
              inst_ready_o <= 1'b1;
              busy_o       <= 1'b1;
`ifdef VPS_CHECKSUM_EN
              checksum_o   <= '0;
`endif
            end else if (start_i) begin
              err_o <= 1'b1;
            end
          end
          LOAD: begin
            if (hs_s) begin
              inst_we_o     <= 1'b1;
              inst_addr_o   <= index_r;
              instruction_o <= inst_i;
              index_r       <= index_r + ADDR_WIDTH'(1);
`ifdef VPS_CHECKSUM_EN
              checksum_o    <= checksum_o ^ inst_i;
`endif
              if (last_s) begin
                state_r      <= DRAIN;
                inst_ready_o <= 1'b0;
              end
            end
          end
          DRAIN: begin
            state_r   <= RUN;
            dp_run_o  <= 1'b1;
            run_cnt_r <= 32'd0;
          end
          RUN: begin
            run_cnt_r <= run_nxt_s;
            // A halt coinciding with the limit wins, so no timeout in that case
            if (dp_halt_i || limit_s) begin
              state_r      <= DONE;
              dp_run_o     <= 1'b0;
              done_o       <= 1'b1;
              exec_count_o <= exec_sat_s;
              timeout_o    <= ~dp_halt_i;
            end
          end
          DONE: begin
            state_r <= IDLE;
            busy_o  <= 1'b0;
          end
          default: begin
            state_r      <= IDLE;
            inst_ready_o <= 1'b0;
            dp_run_o     <= 1'b0;
            busy_o       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
